// File: rtl/slot_bank_if.sv
// rtl/slot_bank_if.sv - switch/reel/display signal bundle for the slot credit bank
interface slot_bank_if #(
  parameter int REELS   = 4,
  parameter int DIGIT_W = 4,
  parameter int BAL_W   = 27
);
  logic [3:0]               bet_sel;
  logic                     spin_req;
  logic [REELS*DIGIT_W-1:0] reels;
  logic                     reels_valid;
  logic [BAL_W-1:0]         balance;
  logic                     busy;
  logic                     result_valid;
  logic [1:0]               result_code;
  logic [BAL_W-1:0]         last_payout;

  modport master (
    output bet_sel, spin_req, reels, reels_valid,
    input  balance, busy, result_valid, result_code, last_payout
  );

  modport slave (
    input  bet_sel, spin_req, reels, reels_valid,
    output balance, busy, result_valid, result_code, last_payout
  );
endinterface

// File: rtl/slot_bank.sv
// rtl/slot_bank.sv - credit bank: bet debit, reel wait with timeout refund, match scoring, saturating payout
module slot_bank #(
  parameter int REELS        = 4,
  parameter int DIGIT_W      = 4,
  parameter int BAL_W        = 27,
  parameter int START_BAL    = 100,
  parameter int MAX_BAL      = 1000,
  parameter int JACKPOT_MULT = 2,
  parameter int PARTIAL_MULT = 1,
  parameter int PARTIAL_MIN  = 3,
  parameter int TIMEOUT      = 1024
) (
  input  logic       clk,
  input  logic       rst,
  slot_bank_if.slave bus
);

  localparam int PW = BAL_W + 9;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = REELS * DIGIT_W;

  localparam logic [1:0] CODE_LOSE    = 2'd0;
  localparam logic [1:0] CODE_PARTIAL = 2'd1;
  localparam logic [1:0] CODE_JACKPOT = 2'd2;
  localparam logic [1:0] CODE_REJECT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_REELS,
    ST_SCORE,
    ST_PAYOUT
  } state_e;

  state_e           state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [BAL_W-1:0] bet_q, bet_d;
  logic [RW-1:0]    reels_q, reels_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [PW-1:0]    payout_q, payout_d;
  logic [1:0]       code_q, code_d;
  logic             result_valid_q, result_valid_d;
  logic [1:0]       result_code_q, result_code_d;
  logic [BAL_W-1:0] last_payout_q, last_payout_d;

  logic [BAL_W-1:0] bet_dec;
  logic [3:0]       match_cnt;

  function automatic logic [BAL_W-1:0] decode_bet(input logic [3:0] sel);
    if (sel[3])      return BAL_W'(100);
    else if (sel[2]) return BAL_W'(50);
    else if (sel[1]) return BAL_W'(10);
    else if (sel[0]) return BAL_W'(1);
    else             return '0;
  endfunction

  // Widened sum so a large payout cannot wrap below the ceiling before clamping.
  function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] base,
                                               input logic [PW-1:0]    add);
    logic [PW-1:0] sum;
    sum = PW'(base) + add;
    if (sum > PW'(MAX_BAL)) return BAL_W'(MAX_BAL);
    else                    return sum[BAL_W-1:0];
  endfunction

  assign bet_dec = decode_bet(bus.bet_sel);

  always_comb begin
    match_cnt = 4'd1;
    for (int i = 1; i < REELS; i++) begin
      if (reels_q[i*DIGIT_W +: DIGIT_W] == reels_q[DIGIT_W-1:0]) begin
        match_cnt = match_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    balance_d      = balance_q;
    bet_d          = bet_q;
    reels_d        = reels_q;
    tmo_d          = tmo_q;
    payout_d       = payout_q;
    code_d         = code_q;
    result_valid_d = 1'b0;
    result_code_d  = result_code_q;
    last_payout_d  = last_payout_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.spin_req) begin
          if (bet_dec == '0 || bet_dec > balance_q) begin
            result_valid_d = 1'b1;
            result_code_d  = CODE_REJECT;
            last_payout_d  = '0;
          end else begin
            bet_d     = bet_dec;
            balance_d = balance_q - bet_dec;
            tmo_d     = '0;
            state_d   = ST_WAIT_REELS;
          end
        end
      end
      ST_WAIT_REELS: begin
        // A reel result arriving on the last allowed cycle still wins over the refund.
        if (bus.reels_valid) begin
          reels_d = bus.reels;
          state_d = ST_SCORE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          balance_d      = sat_add(balance_q, PW'(bet_q));
          result_valid_d = 1'b1;
          result_code_d  = CODE_REJECT;
          last_payout_d  = '0;
          state_d        = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_SCORE: begin
        if (match_cnt == 4'(REELS)) begin
          code_d   = CODE_JACKPOT;
          payout_d = PW'(bet_q) * PW'(JACKPOT_MULT);
        end else if (match_cnt >= 4'(PARTIAL_MIN)) begin
          code_d   = CODE_PARTIAL;
          payout_d = PW'(bet_q) * PW'(PARTIAL_MULT);
        end else begin
          code_d   = CODE_LOSE;
          payout_d = '0;
        end
        state_d = ST_PAYOUT;
      end
      ST_PAYOUT: begin
        balance_d      = sat_add(balance_q, payout_q);
        result_valid_d = 1'b1;
        result_code_d  = code_q;
        last_payout_d  = payout_q[BAL_W-1:0];
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      balance_q      <= BAL_W'(START_BAL);
      bet_q          <= '0;
      reels_q        <= '0;
      tmo_q          <= '0;
      payout_q       <= '0;
      code_q         <= CODE_LOSE;
      result_valid_q <= 1'b0;
      result_code_q  <= CODE_LOSE;
      last_payout_q  <= '0;
    end else begin
      state_q        <= state_d;
      balance_q      <= balance_d;
      bet_q          <= bet_d;
      reels_q        <= reels_d;
      tmo_q          <= tmo_d;
      payout_q       <= payout_d;
      code_q         <= code_d;
      result_valid_q <= result_valid_d;
      result_code_q  <= result_code_d;
      last_payout_q  <= last_payout_d;
    end
  end

  assign bus.balance      = balance_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.result_valid = result_valid_q;
  assign bus.result_code  = result_code_q;
  assign bus.last_payout  = last_payout_q;

endmodule

// File: tb/tb_slot_bank.sv
// tb/tb_slot_bank.sv - randomized self-checking bench for slot_bank against a credit-ledger model
module tb_slot_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   err = 0;
  int   bal_a = 100;

  always #5 clk = ~clk;

  slot_bank_if #(.REELS(4), .DIGIT_W(4), .BAL_W(27)) if_a ();
  slot_bank_if #(.REELS(4), .DIGIT_W(4), .BAL_W(27)) if_b ();

  slot_bank #(.START_BAL(100), .TIMEOUT(16)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  slot_bank #(.START_BAL(990), .TIMEOUT(16)) u_b (.clk(clk), .rst(rst), .bus(if_b));

  function automatic int decode(input logic [3:0] b);
    if (b[3]) return 100;
    if (b[2]) return 50;
    if (b[1]) return 10;
    if (b[0]) return 1;
    return 0;
  endfunction

  function automatic int cap(input int v);
    return (v > 1000) ? 1000 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete spin on instance A; d >= 16 means reels never arrive.
  task automatic do_spin(input logic [3:0] bs, input logic [15:0] rv, input int d, input int gap);
    int bet, m, code, pay;
    for (int g = 0; g < gap; g++) begin
      if_a.reels_valid = 1'($urandom);
      if_a.reels       = 16'($urandom);
      tick();
    end
    if_a.reels_valid = 1'b0;
    if (gap > 0) begin
      vec++;
      if (if_a.busy !== 1'b0 || if_a.balance !== 27'(bal_a) || if_a.result_valid !== 1'b0) begin
        err++;
        $display("FAIL idle_stable busy=%0d bal=%0d rv=%0d exp_bal=%0d", if_a.busy, if_a.balance, if_a.result_valid, bal_a);
      end
    end
    bet = decode(bs);
    if_a.bet_sel  = bs;
    if_a.spin_req = 1'b1;
    tick();
    if_a.spin_req = 1'b0;
    if (bet == 0 || bet > bal_a) begin
      vec++;
      if (if_a.result_valid !== 1'b1 || if_a.result_code !== 2'd3 || if_a.last_payout !== 27'd0) begin
        err++;
        $display("FAIL reject_strobe rv=%0d code=%0d pay=%0d exp rv=1 code=3 pay=0", if_a.result_valid, if_a.result_code, if_a.last_payout);
      end
      vec++;
      if (if_a.busy !== 1'b0 || if_a.balance !== 27'(bal_a)) begin
        err++;
        $display("FAIL reject_state busy=%0d bal=%0d exp busy=0 bal=%0d", if_a.busy, if_a.balance, bal_a);
      end
      tick();
      vec++;
      if (if_a.result_valid !== 1'b0 || if_a.busy !== 1'b0) begin
        err++;
        $display("FAIL reject_pulse rv=%0d busy=%0d exp 0 0", if_a.result_valid, if_a.busy);
      end
      return;
    end
    bal_a = bal_a - bet;
    vec++;
    if (if_a.busy !== 1'b1 || if_a.balance !== 27'(bal_a) || if_a.result_valid !== 1'b0) begin
      err++;
      $display("FAIL accept busy=%0d bal=%0d rv=%0d exp busy=1 bal=%0d rv=0", if_a.busy, if_a.balance, if_a.result_valid, bal_a);
    end
    if_a.bet_sel = 4'($urandom);
    if (d >= 16) begin
      for (int k = 1; k < 16; k++) begin
        if_a.spin_req = 1'($urandom);
        tick();
        vec++;
        if (if_a.result_valid !== 1'b0 || if_a.busy !== 1'b1) begin
          err++;
          $display("FAIL timeout_wait cyc=%0d rv=%0d busy=%0d exp rv=0 busy=1", k, if_a.result_valid, if_a.busy);
        end
      end
      if_a.spin_req = 1'b0;
      tick();
      bal_a = cap(bal_a + bet);
      vec++;
      if (if_a.result_valid !== 1'b1 || if_a.result_code !== 2'd3 || if_a.last_payout !== 27'd0 ||
          if_a.balance !== 27'(bal_a) || if_a.busy !== 1'b0) begin
        err++;
        $display("FAIL timeout_refund rv=%0d code=%0d pay=%0d bal=%0d busy=%0d exp 1 3 0 %0d 0",
                 if_a.result_valid, if_a.result_code, if_a.last_payout, if_a.balance, if_a.busy, bal_a);
      end
      return;
    end
    for (int k = 0; k < d; k++) begin
      if_a.spin_req = 1'($urandom);
      tick();
      vec++;
      if (if_a.result_valid !== 1'b0 || if_a.busy !== 1'b1 || if_a.balance !== 27'(bal_a)) begin
        err++;
        $display("FAIL wait_reels rv=%0d busy=%0d bal=%0d exp 0 1 %0d", if_a.result_valid, if_a.busy, if_a.balance, bal_a);
      end
    end
    if_a.spin_req    = 1'b0;
    if_a.reels       = rv;
    if_a.reels_valid = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      if_a.reels_valid = 1'($urandom);
      if_a.reels       = 16'($urandom);
      if_a.spin_req    = 1'($urandom);
      vec++;
      if (if_a.result_valid !== 1'b0 || if_a.busy !== 1'b1) begin
        err++;
        $display("FAIL score_phase step=%0d rv=%0d busy=%0d exp 0 1", k, if_a.result_valid, if_a.busy);
      end
      tick();
    end
    if_a.reels_valid = 1'b0;
    if_a.spin_req    = 1'b0;
    m = 1;
    for (int i = 1; i < 4; i++) if (((rv >> (4 * i)) & 16'hf) == (rv & 16'hf)) m++;
    code = (m == 4) ? 2 : (m >= 3) ? 1 : 0;
    pay  = (code == 2) ? bet * 2 : (code == 1) ? bet : 0;
    bal_a = cap(bal_a + pay);
    vec++;
    if (if_a.result_valid !== 1'b1 || if_a.result_code !== 2'(code) || if_a.last_payout !== 27'(pay) ||
        if_a.balance !== 27'(bal_a) || if_a.busy !== 1'b0) begin
      err++;
      $display("FAIL payout rv=%0d code=%0d pay=%0d bal=%0d busy=%0d exp 1 %0d %0d %0d 0",
               if_a.result_valid, if_a.result_code, if_a.last_payout, if_a.balance, if_a.busy, code, pay, bal_a);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bal_a = 100;
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if (if_a.balance !== 27'd100 || if_a.busy !== 1'b0 || if_a.result_valid !== 1'b0 ||
        if_a.result_code !== 2'd0 || if_a.last_payout !== 27'd0) begin
      err++;
      $display("FAIL reset_a bal=%0d busy=%0d rv=%0d code=%0d pay=%0d exp 100 0 0 0 0",
               if_a.balance, if_a.busy, if_a.result_valid, if_a.result_code, if_a.last_payout);
    end
    vec++;
    if (if_b.balance !== 27'd990 || if_b.busy !== 1'b0 || if_b.result_valid !== 1'b0) begin
      err++;
      $display("FAIL reset_b bal=%0d busy=%0d rv=%0d exp 990 0 0", if_b.balance, if_b.busy, if_b.result_valid);
    end
  endtask

  task automatic test_jackpot();
    do_spin(4'b0010, 16'h7777, 0, 1);
    tick();
    vec++;
    if (if_a.result_valid !== 1'b0 || if_a.result_code !== 2'd2 || if_a.last_payout !== 27'd20) begin
      err++;
      $display("FAIL jackpot_hold rv=%0d code=%0d pay=%0d exp 0 2 20", if_a.result_valid, if_a.result_code, if_a.last_payout);
    end
  endtask

  task automatic test_partial_lose_reject();
    do_reset();
    do_spin(4'b0100, 16'h5333, 2, 0);
    do_spin(4'b1000, 16'h4321, 1, 0);
    do_spin(4'b0001, 16'h0000, 0, 1);
    do_spin(4'b0000, 16'h0000, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_spin(4'b0010, 16'h1111, 0, 0);
    do_spin(4'b0010, 16'h2922, 0, 0);
    do_spin(4'b0011, 16'h8765, 0, 0);
  endtask

  task automatic test_timeout();
    do_reset();
    do_spin(4'b0010, 16'h0000, 16, 0);
  endtask

  task automatic test_saturation();
    do_reset();
    if_b.bet_sel  = 4'b1000;
    if_b.spin_req = 1'b1;
    tick();
    if_b.spin_req = 1'b0;
    vec++;
    if (if_b.balance !== 27'd890 || if_b.busy !== 1'b1) begin
      err++;
      $display("FAIL sat_accept bal=%0d busy=%0d exp 890 1", if_b.balance, if_b.busy);
    end
    if_b.reels       = 16'h4444;
    if_b.reels_valid = 1'b1;
    tick();
    if_b.reels_valid = 1'b0;
    tick();
    tick();
    vec++;
    if (if_b.result_valid !== 1'b1 || if_b.result_code !== 2'd2 || if_b.last_payout !== 27'd200 ||
        if_b.balance !== 27'd1000) begin
      err++;
      $display("FAIL sat_payout rv=%0d code=%0d pay=%0d bal=%0d exp 1 2 200 1000",
               if_b.result_valid, if_b.result_code, if_b.last_payout, if_b.balance);
    end
  endtask

  task automatic test_abort();
    do_reset();
    if_a.bet_sel  = 4'b0010;
    if_a.spin_req = 1'b1;
    tick();
    if_a.spin_req    = 1'b0;
    if_a.reels       = 16'h3333;
    if_a.reels_valid = 1'b1;
    tick();
    if_a.reels_valid = 1'b0;
    rst = 1'b1;
    tick();
    vec++;
    if (if_a.balance !== 27'd100 || if_a.busy !== 1'b0 || if_a.result_valid !== 1'b0) begin
      err++;
      $display("FAIL abort_reset bal=%0d busy=%0d rv=%0d exp 100 0 0", if_a.balance, if_a.busy, if_a.result_valid);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vec++;
      if (if_a.result_valid !== 1'b0 || if_a.busy !== 1'b0 || if_a.balance !== 27'd100) begin
        err++;
        $display("FAIL abort_quiet cyc=%0d rv=%0d busy=%0d bal=%0d exp 0 0 100", k, if_a.result_valid, if_a.busy, if_a.balance);
      end
    end
    bal_a = 100;
  endtask

  task automatic test_random();
    logic [15:0] rv;
    logic [3:0]  base;
    int          d;
    for (int n = 0; n < 60; n++) begin
      if (bal_a < 10) do_reset();
      base = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        rv[4*i +: 4] = ($urandom_range(0, 2) != 0) ? base : 4'($urandom_range(0, 15));
      end
      d = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 5);
      do_spin(4'($urandom), rv, d, $urandom_range(0, 2));
    end
  endtask

  initial begin
    if_a.bet_sel = 4'd0; if_a.spin_req = 1'b0; if_a.reels = 16'd0; if_a.reels_valid = 1'b0;
    if_b.bet_sel = 4'd0; if_b.spin_req = 1'b0; if_b.reels = 16'd0; if_b.reels_valid = 1'b0;
    test_reset();
    test_jackpot();
    test_partial_lose_reject();
    test_back_to_back();
    test_timeout();
    test_saturation();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/slot_bank.md
# slot_bank

Parametrised credit bank for the slot-machine game. It accepts a bet and a spin request, debits the bet, and waits for a reel result from the random-number/reel block. It then scores the match count, credits a mode-dependent payout with saturation, and reports the outcome through a one-cycle result strobe. It sits between the switch/debounce front end and the display driver, and supersedes the fixed four-reel bank with a handshaked, multi-tier payout engine.

## Interface
- REELS, 4: number of reels/digits (2..8)
- DIGIT_W, 4: bits per reel digit
- BAL_W, 27: balance width
- START_BAL, 100: balance loaded on reset
- MAX_BAL, 1000: saturation ceiling (must be < 2^BAL_W)
- JACKPOT_MULT, 2: payout multiplier when all reels match (0..255)
- PARTIAL_MULT, 1: payout multiplier for a partial match (0..255)
- PARTIAL_MIN, 3: minimum match count for a partial win (2..REELS-1)
- TIMEOUT, 1024: maximum cycles spent waiting for reels
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- bet_sel  in  4  bet switches; priority bit3=100 > bit2=50 > bit1=10 > bit0=1; all low = bet 0
- spin_req  in  1  spin request, sampled only in IDLE
- reels  in  REELS*DIGIT_W  reel digits; reel 0 in LSBs
- reels_valid  in  1  reels field valid, sampled only in WAIT_REELS
- balance  out  BAL_W  current credit
- busy  out  1  high in every state except IDLE
- result_valid  out  1  one-cycle outcome strobe
- result_code  out  2  0 lose, 1 partial, 2 jackpot, 3 rejected/refunded; held until next strobe
- last_payout  out  BAL_W  nominal payout of last spin (pre-saturation, clipped to BAL_W); held

## Operation
- States: IDLE, WAIT_REELS, SCORE, PAYOUT.
- IDLE, spin_req=1, bet = decode(bet_sel):
  - bet == 0 or bet > balance: reject. Strobe result_valid with code 3 and last_payout 0. Balance unchanged; stay in IDLE.
  - Otherwise: latch bet, set balance = balance - bet, clear the timeout counter, go to WAIT_REELS.
- WAIT_REELS:
  - reels_valid=1: latch reels, go to SCORE.
  - Timeout counter reaches TIMEOUT-1 without reels_valid: refund the bet (saturating add), strobe code 3 with last_payout 0, go to IDLE.
- SCORE:
  - match = 1 + (number of reels i in 1..REELS-1 equal to reel 0).
  - match == REELS: jackpot, payout = bet*JACKPOT_MULT.
  - PARTIAL_MIN <= match < REELS: partial, payout = bet*PARTIAL_MULT.
  - Otherwise: lose, payout = 0.
  - Register payout and code, go to PAYOUT.
- PAYOUT: set balance = min(balance + payout, MAX_BAL). Strobe result_valid, update result_code and last_payout, go to IDLE.
- Arithmetic: the product and sum use BAL_W+9 bits, so there is no wrap before saturation. The balance never underflows because the bet is checked before the debit.
- spin_req while busy is ignored, not queued. reels_valid outside WAIT_REELS is ignored. bet_sel changes after acceptance have no effect.
- Reset mid-operation: the spin is aborted with no refund. Balance = START_BAL, state = IDLE.

## Timing
- Reset values: balance=START_BAL, busy=0, result_valid=0, result_code=0, last_payout=0, state IDLE.
- Accept at edge T: the debited balance and busy=1 are visible after T.
- Reject at edge T: result_valid=1 for exactly the cycle after T. busy stays 0.
- Earliest reels_valid sampling is edge T+1.
- reels_valid sampled at edge R: SCORE runs in the cycle after R. After edge R+2, the balance is updated, result_valid=1 for one cycle, and busy=0.
- A new spin can be accepted at edge R+3.
- Minimum spin latency, request to strobe: 4 edges. Throughput: 1 spin per 4 cycles.
- Timeout: the refund and strobe occur at the edge where WAIT_REELS has lasted TIMEOUT cycles.

## Test plan
- Reset: rst high 2 cycles -> balance=100, busy=0, result_valid=0, result_code=0, last_payout=0.
- Jackpot: bet_sel=0010, spin, reels 7,7,7,7 -> balance 90 after accept, then 110. Code 2, last_payout 20, one-cycle strobe at R+2.
- Partial and lose:
  - Bet 50, reels 3,3,3,5 -> balance 50, then 100, code 1.
  - Then bet 100, reels 1,2,3,4 -> balance 0, code 0.
- Reject:
  - At balance 0, bet_sel=0001 spin -> code 3, balance stays 0, busy never rises.
  - bet_sel=0000 spin -> code 3.
- Saturation: START_BAL=990, bet_sel=1000, jackpot -> balance 890, then 1000 (not 1090). last_payout=200.
- Timeout and abort:
  - TIMEOUT=16, bet 10, no reels_valid -> code 3 and balance 100 after 16 cycles in WAIT_REELS.
  - Separately, rst asserted in SCORE -> balance=100, IDLE, and no strobe from the aborted spin.
